seven_seg_scanner: RTL and testbench

Time-multiplexed scan driver for a multi-digit common-anode seven-segment display. It holds a packed hex value and steps through the digits in turn. For each digit it presents that digit's nibble on `hex_value`, which feeds the `seven_seg_decoder` stage directly downstream, and drives the matching active-low anode. A short blanking gap between digits suppresses ghosting, and new values are applied only at frame boundaries so the display never shows a torn value.

---
 rtl/seven_seg_pkg.sv | 22 ++
 rtl/seven_seg_scanner_tick_gen.sv | 43 ++++
 rtl/seven_seg_scanner.sv | 108 ++++++++++
 tb/tb_seven_seg_scanner.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the seven-segment scan driver.
// Leading-zero suppression is selected by SEVEN_SEG_LZ_SUPPRESS_EN in seven_seg_scanner.
package seven_seg_pkg;

    typedef enum logic {
        SCAN_GAP  = 1'b0,
        SCAN_SHOW = 1'b1
    } scan_state_e;

    localparam int DEF_NUM_DIGITS   = 4;
    localparam int DEF_REFRESH_DIV  = 50000;
    localparam int DEF_BLANK_CYCLES = 500;

    localparam int MAX_DIGITS = 8;
    localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

    // True when digit k is a leading zero: k > 0 and it and every higher nibble are zero.
    function automatic logic lz_blank(input logic [4*MAX_DIGITS-1:0] val, input int unsigned k);
        return (k != 0) && ((val >> (4 * k)) == '0);
    endfunction

endpackage

// File: rtl/seven_seg_scanner_tick_gen.sv
// Slot counter for the scan driver: flags the last cycle of a slot and of its blanking gap.
module scan_tick_gen
    import seven_seg_pkg::*;
#(
    parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic clk,
    input  logic rst,
    output logic slot_end,
    output logic gap_end
);

    localparam int CNT_W = $clog2(REFRESH_DIV);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign slot_end = (cnt_q == CNT_W'(REFRESH_DIV - 1));

    generate
        if (BLANK_CYCLES == 0) begin : g_no_gap
            assign gap_end = 1'b0;
        end else begin : g_gap
            assign gap_end = (cnt_q == CNT_W'(BLANK_CYCLES - 1));
        end
    endgenerate

    always_comb begin
        cnt_d = slot_end ? '0 : cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process evaluation order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment scan driver with frame-aligned value updates.
// Define SEVEN_SEG_LZ_SUPPRESS_EN to blank leading-zero digits.
module seven_seg_scanner
    import seven_seg_pkg::*;
#(
    parameter int NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int REFRESH_DIV  = DEF_REFRESH_DIV,
    parameter int BLANK_CYCLES = DEF_BLANK_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic                    load,
    input  logic [NUM_DIGITS-1:0]   digit_en,
    output logic [3:0]              hex_value,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic                    frame_done
);

    localparam int IDX_W = $clog2(NUM_DIGITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam scan_state_e SLOT_ENTRY = (BLANK_CYCLES == 0) ? SCAN_SHOW : SCAN_GAP;

    logic                    slot_end;
    logic                    gap_end;

    scan_state_e             state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [4*NUM_DIGITS-1:0] s_q, s_d;
    logic [4*NUM_DIGITS-1:0] d_q, d_d;
    logic [3:0]              hex_q, hex_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic                    frame_q, frame_d;
    logic                    lz;

    scan_tick_gen #(
        .REFRESH_DIV  (REFRESH_DIV),
        .BLANK_CYCLES (BLANK_CYCLES)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .slot_end (slot_end),
        .gap_end  (gap_end)
    );

    // Outputs are registered from next-state values so they move on the same
    // edge as the slot counter and the decoder input settles during the gap.
    // NOTE: every variable gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        d_d     = d_q;
        frame_d = 1'b0;
        s_d     = load ? value_in : s_q;

        if (slot_end) begin
            state_d = SLOT_ENTRY;
            if (idx_q == IDX_LAST) begin
                idx_d   = '0;
                d_d     = s_q;
                frame_d = 1'b1;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end else if (state_q == SCAN_GAP && gap_end) begin
            state_d = SCAN_SHOW;
        end

        hex_d = d_d[4*idx_d +: 4];

`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
        lz = lz_blank(32'(d_d), 32'(idx_d));
`else
        lz = 1'b0;
`endif

        anode_d = ANODE_OFF[NUM_DIGITS-1:0];
        if (state_d == SCAN_SHOW && digit_en[idx_d] && !lz) begin
            anode_d[idx_d] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= SLOT_ENTRY;
            idx_q   <= '0;
            s_q     <= '0;
            d_q     <= '0;
            hex_q   <= '0;
            anode_q <= ANODE_OFF[NUM_DIGITS-1:0];
            frame_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            s_q     <= s_d;
            d_q     <= d_d;
            hex_q   <= hex_d;
            anode_q <= anode_d;
            frame_q <= frame_d;
        end
    end

    assign hex_value  = hex_q;
    assign anode_n    = anode_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed bench for seven_seg_scanner: one instance with a blanking gap, one without.
module tb_seven_seg_scanner;

    localparam int ND  = 4;
    localparam int DIV = 8;
    localparam int FRAME = ND * DIV;

`ifdef SEVEN_SEG_LZ_SUPPRESS_EN
    localparam bit LZ_ON = 1'b1;
`else
    localparam bit LZ_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic [15:0]   value_in;
    logic          load;
    logic [3:0]    digit_en;

    logic [3:0]    hex_g, hex_z;
    logic [3:0]    an_g, an_z;
    logic          fd_g, fd_z;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    seven_seg_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV), .BLANK_CYCLES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .load       (load),
        .digit_en   (digit_en),
        .hex_value  (hex_g),
        .anode_n    (an_g),
        .frame_done (fd_g)
    );

    seven_seg_scanner #(.NUM_DIGITS(ND), .REFRESH_DIV(DIV), .BLANK_CYCLES(0)) dut0 (
        .clk        (clk),
        .rst        (rst),
        .value_in   (value_in),
        .load       (load),
        .digit_en   (digit_en),
        .hex_value  (hex_z),
        .anode_n    (an_z),
        .frame_done (fd_z)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Entered at the negedge just after a wrap; checks one full frame showing val
    // and returns at the negedge after the next wrap.
    task automatic run_frame(input logic [15:0] val, input int load_at,
                             input logic [15:0] load_val, input logic [3:0] next_en);
        logic [3:0] en;
        logic [3:0] one_hot;
        logic [3:0] exp_g, exp_z;
        int slot, ph;
        bit sup;
        en = digit_en;
        for (int i = 0; i < FRAME; i++) begin
            slot    = i / DIV;
            ph      = i % DIV;
            sup     = LZ_ON && (slot > 0) && ((val >> (4 * slot)) == 16'h0);
            one_hot = 4'b0001 << slot;
            exp_g   = (ph >= 2 && en[slot] && !sup) ? ~one_hot : 4'hF;
            exp_z   = (en[slot] && !sup) ? ~one_hot : 4'hF;
            chk($sformatf("val%h_c%0d_anode", val, i), {28'h0, an_g}, {28'h0, exp_g});
            chk($sformatf("val%h_c%0d_anode_nogap", val, i), {28'h0, an_z}, {28'h0, exp_z});
            chk($sformatf("val%h_c%0d_hex", val, i), {28'h0, hex_g}, {28'h0, val[4*slot +: 4]});
            chk($sformatf("val%h_c%0d_frame_done", val, i), {31'h0, fd_g}, {31'h0, (i == 0)});
            if (i == load_at) begin
                load     = 1'b1;
                value_in = load_val;
            end else begin
                load = 1'b0;
            end
            if (i == FRAME - 1) digit_en = next_en;
            @(negedge clk);
        end
        load = 1'b0;
        chk($sformatf("val%h_frame_period", val), {31'h0, fd_g}, 32'h1);
    endtask

    initial begin
        rst      = 1'b1;
        load     = 1'b0;
        value_in = 16'h0;
        digit_en = 4'hF;
        repeat (2) @(negedge clk);
        chk("reset_anode", {28'h0, an_g}, 32'hF);
        chk("reset_anode_nogap", {28'h0, an_z}, 32'hF);
        chk("reset_hex", {28'h0, hex_g}, 32'h0);
        chk("reset_frame_done", {31'h0, fd_g}, 32'h0);

        // Release reset and load 0x1234 on the first active edge.
        rst      = 1'b0;
        load     = 1'b1;
        value_in = 16'h1234;
        @(negedge clk);
        load = 1'b0;
        chk("first_slot_gap_anode", {28'h0, an_g}, 32'hF);
        chk("first_slot_hex", {28'h0, hex_g}, 32'h0);
        chk("first_slot_nogap_anode", {28'h0, an_z}, 32'hE);
        @(negedge clk);
        chk("first_slot_show_anode", {28'h0, an_g}, 32'hE);

        begin : wait_wrap
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 3 * FRAME && !seen; k++) begin
                if (fd_g) seen = 1'b1;
                else @(negedge clk);
            end
            chk("first_wrap_seen", {31'h0, seen}, 32'h1);
        end

        run_frame(16'h1234, -1, 16'h0, 4'b0101);
        run_frame(16'h1234, -1, 16'h0, 4'hF);            // masked digits 1 and 3
        run_frame(16'h1234, 18, 16'hABCD, 4'hF);         // load during digit 2 slot
        run_frame(16'hABCD, FRAME - 1, 16'h0005, 4'hF);  // load coincides with wrap
        run_frame(16'hABCD, -1, 16'h0, 4'hF);
        run_frame(16'h0005, 5, 16'h0000, 4'hF);
        run_frame(16'h0000, -1, 16'h0, 4'hF);

        // Asynchronous reset in the middle of a SHOW phase.
        repeat (4) @(negedge clk);
        chk("pre_reset_show_anode", {28'h0, an_g}, 32'hE);
        #2 rst = 1'b1;
        #1;
        chk("async_reset_anode", {28'h0, an_g}, 32'hF);
        chk("async_reset_anode_nogap", {28'h0, an_z}, 32'hF);
        chk("async_reset_hex", {28'h0, hex_g}, 32'h0);
        chk("async_reset_frame_done", {31'h0, fd_g}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("restart_gap_anode", {28'h0, an_g}, 32'hF);
        chk("restart_nogap_anode", {28'h0, an_z}, 32'hE);
        @(negedge clk);
        chk("restart_show_anode", {28'h0, an_g}, 32'hE);
        chk("restart_hex", {28'h0, hex_g}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule
